// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, data word, and the
// arbiter's FSM state and owner encoding.
package cpu_types_pkg;

  localparam int CPUS = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Owner is {core, isData}; isData=1 selects the dcache of that core.
  typedef struct packed {
    logic core;
    logic isData;
  } arb_owner_t;

endpackage

// File: rtl/memory_arbiter.sv
// Serialises the four cache ports of a dual-core system onto one RAM port,
// with dcache-over-icache priority and round-robin between cores.
module memory_arbiter
  import cpu_types_pkg::*;
(
  input  logic            CLK,
  input  logic            nRST,
  input  logic [CPUS-1:0] iREN,
  input  word_t           iaddr  [CPUS],
  output logic [CPUS-1:0] iwait,
  output word_t           iload  [CPUS],
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  input  word_t           daddr  [CPUS],
  input  word_t           dstore [CPUS],
  output logic [CPUS-1:0] dwait,
  output word_t           dload  [CPUS],
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore,
  input  word_t           ramload,
  input  ramstate_t       ramstate
);

  arb_state_t      r_state;
  arb_owner_t      r_owner;
  logic            r_rr;

  logic [CPUS-1:0] w_dReq;
  logic            w_anyReq;
  logic            w_ownerReq;
  logic            w_active;
  logic            w_done;
  arb_owner_t      w_nextOwner;

  assign w_dReq     = dREN | dWEN;
  assign w_anyReq   = (|w_dReq) | (|iREN);
  assign w_ownerReq = r_owner.isData ? w_dReq[r_owner.core] : iREN[r_owner.core];
  assign w_active   = (r_state == XFER) && w_ownerReq;
  assign w_done     = w_active && (ramstate == ACCESS);

  // Data class first; inside a class the core pointed to by r_rr wins.
  always_comb begin
    w_nextOwner.core   = ~r_rr;
    w_nextOwner.isData = 1'b0;
    if (w_dReq[r_rr]) begin
      w_nextOwner.core   = r_rr;
      w_nextOwner.isData = 1'b1;
    end else if (w_dReq[~r_rr]) begin
      w_nextOwner.core   = ~r_rr;
      w_nextOwner.isData = 1'b1;
    end else if (iREN[r_rr]) begin
      w_nextOwner.core   = r_rr;
      w_nextOwner.isData = 1'b0;
    end
  end

  // A dropped owner request returns to IDLE without touching r_rr.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_rr    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_state <= XFER;
            r_owner <= w_nextOwner;
          end
        end
        XFER: begin
          if (!w_ownerReq) begin
            r_state <= IDLE;
          end else if (ramstate == ACCESS) begin
            r_state <= IDLE;
            r_rr    <= ~r_rr;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    for (int c = 0; c < CPUS; c++) begin
      iload[c] = '0;
      dload[c] = '0;
    end
    if (w_active) begin
      if (r_owner.isData) begin
        ramaddr  = daddr[r_owner.core];
        ramstore = dstore[r_owner.core];
        ramWEN   = dWEN[r_owner.core];
        ramREN   = dREN[r_owner.core] & ~dWEN[r_owner.core];
      end else begin
        ramaddr  = iaddr[r_owner.core];
        ramREN   = 1'b1;
      end
    end
    if (w_done) begin
      if (r_owner.isData) begin
        dwait[r_owner.core] = 1'b0;
        dload[r_owner.core] = ramload;
      end else begin
        iwait[r_owner.core] = 1'b0;
        iload[r_owner.core] = ramload;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed, table-driven bench for memory_arbiter: one vector per clock
// cycle plus a hand-written round-robin run starting from reset.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam word_t LOAD_VAL = 32'hDEADBEEF;

  logic      CLK;
  logic      nRST;
  logic [1:0] iREN, iwait, dREN, dWEN, dwait;
  word_t     iaddr [2];
  word_t     iload [2];
  word_t     daddr [2];
  word_t     dstore [2];
  word_t     dload [2];
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    logic       nrst;
    logic [1:0] iren;
    logic [1:0] dren;
    logic [1:0] dwen;
    ramstate_t  rs;
    logic       eRen;
    logic       eWen;
    word_t      eAddr;
    word_t      eStore;
    logic [1:0] eIwait;
    logic [1:0] eDwait;
  } vec_t;

  vec_t vecs[$];

  memory_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic addVec(input logic nrst, input logic [1:0] iren, input logic [1:0] dren,
                        input logic [1:0] dwen, input ramstate_t rs, input logic eRen,
                        input logic eWen, input word_t eAddr, input word_t eStore,
                        input logic [1:0] eIwait, input logic [1:0] eDwait);
    vec_t v;
    v.nrst = nrst; v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs;
    v.eRen = eRen; v.eWen = eWen; v.eAddr = eAddr; v.eStore = eStore;
    v.eIwait = eIwait; v.eDwait = eDwait;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    nRST     = v.nrst;
    iREN     = v.iren;
    dREN     = v.dren;
    dWEN     = v.dwen;
    ramstate = v.rs;
  endtask

  task automatic checkOne(input string name, input logic [127:0] got, input logic [127:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [127:0] expLoads;
    expLoads = {(v.eIwait[1] ? 32'h0 : LOAD_VAL), (v.eIwait[0] ? 32'h0 : LOAD_VAL),
                (v.eDwait[1] ? 32'h0 : LOAD_VAL), (v.eDwait[0] ? 32'h0 : LOAD_VAL)};
    checkOne($sformatf("vec%0d ram", idx),
             {62'd0, ramREN, ramWEN, ramaddr, ramstore},
             {62'd0, v.eRen, v.eWen, v.eAddr, v.eStore});
    checkOne($sformatf("vec%0d waits", idx), {124'd0, iwait, dwait},
             {124'd0, v.eIwait, v.eDwait});
    checkOne($sformatf("vec%0d loads", idx), {iload[1], iload[0], dload[1], dload[0]},
             expLoads);
  endtask

  initial begin
    int grants[$];
    nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; ramstate = FREE;
    iaddr[0]  = 32'h100;      iaddr[1]  = 32'h180;
    daddr[0]  = 32'h40;       daddr[1]  = 32'h200;
    dstore[0] = 32'hAAAA0000; dstore[1] = 32'h12345678;
    ramload   = LOAD_VAL;

    // Reset, then reset asserted in the middle of a core0 dcache read
    addVec(0, 2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    addVec(1, 2'b00, 2'b01, 2'b00, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    addVec(1, 2'b00, 2'b01, 2'b00, BUSY,   1, 0, 32'h40,  32'hAAAA0000, 2'b11, 2'b11);
    addVec(0, 2'b00, 2'b01, 2'b00, BUSY,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    addVec(1, 2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    // Single icache read, ACCESS on the second enabled cycle
    addVec(1, 2'b01, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    addVec(1, 2'b01, 2'b00, 2'b00, BUSY,   1, 0, 32'h100, 32'h0,        2'b11, 2'b11);
    addVec(1, 2'b01, 2'b00, 2'b00, ACCESS, 1, 0, 32'h100, 32'h0,        2'b10, 2'b11);
    addVec(1, 2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    // Data-over-instruction: core1 write first, core0 read after an IDLE cycle
    addVec(1, 2'b01, 2'b00, 2'b10, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    addVec(1, 2'b01, 2'b00, 2'b10, BUSY,   0, 1, 32'h200, 32'h12345678, 2'b11, 2'b11);
    addVec(1, 2'b01, 2'b00, 2'b10, ACCESS, 0, 1, 32'h200, 32'h12345678, 2'b11, 2'b01);
    addVec(1, 2'b01, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    addVec(1, 2'b01, 2'b00, 2'b00, ACCESS, 1, 0, 32'h100, 32'h0,        2'b10, 2'b11);
    addVec(1, 2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    // ERROR for 3 cycles then ACCESS on core1 icache
    addVec(1, 2'b10, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    addVec(1, 2'b10, 2'b00, 2'b00, ERROR,  1, 0, 32'h180, 32'h0,        2'b11, 2'b11);
    addVec(1, 2'b10, 2'b00, 2'b00, ERROR,  1, 0, 32'h180, 32'h0,        2'b11, 2'b11);
    addVec(1, 2'b10, 2'b00, 2'b00, ERROR,  1, 0, 32'h180, 32'h0,        2'b11, 2'b11);
    addVec(1, 2'b10, 2'b00, 2'b00, ACCESS, 1, 0, 32'h180, 32'h0,        2'b01, 2'b11);
    addVec(1, 2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    // Core1 dREN and dWEN together behave as a write
    addVec(1, 2'b00, 2'b10, 2'b10, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    addVec(1, 2'b00, 2'b10, 2'b10, ACCESS, 0, 1, 32'h200, 32'h12345678, 2'b11, 2'b01);
    addVec(1, 2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    // Core1 read dropped mid-transfer: no pulse, pointer stays on core1
    addVec(1, 2'b00, 2'b10, 2'b00, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    addVec(1, 2'b00, 2'b10, 2'b00, BUSY,   1, 0, 32'h200, 32'h12345678, 2'b11, 2'b11);
    addVec(1, 2'b00, 2'b00, 2'b00, ACCESS, 0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    addVec(1, 2'b00, 2'b11, 2'b00, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    addVec(1, 2'b00, 2'b11, 2'b00, ACCESS, 1, 0, 32'h200, 32'h12345678, 2'b11, 2'b01);
    addVec(1, 2'b00, 2'b11, 2'b00, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);
    addVec(1, 2'b00, 2'b11, 2'b00, ACCESS, 1, 0, 32'h40,  32'hAAAA0000, 2'b11, 2'b10);
    addVec(1, 2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,        2'b11, 2'b11);

    foreach (vecs[i]) begin
      @(posedge CLK);
      #1 applyStimulus(vecs[i]);
      @(negedge CLK);
      checkOutput(vecs[i], i);
    end

    // Pointer is on core1 here; reset must bring it back to core0
    @(posedge CLK);
    #1;
    nRST = 1'b0; dREN = 2'b11; dWEN = 2'b00; iREN = 2'b00; ramstate = ACCESS;
    @(negedge CLK);
    checkOne("rr reset ramREN", {127'd0, ramREN}, 128'd0);
    checkOne("rr reset waits", {124'd0, iwait, dwait}, {124'd0, 4'b1111});
    @(posedge CLK);
    #1 nRST = 1'b1;
    for (int cyc = 0; cyc < 30 && grants.size() < 4; cyc++) begin
      @(negedge CLK);
      if (dwait == 2'b10) grants.push_back(0);
      else if (dwait == 2'b01) grants.push_back(1);
      else if (dwait == 2'b00) grants.push_back(9);
    end
    checkOne("rr grant count", 128'(grants.size()), 128'd4);
    for (int k = 0; k < 4; k++) begin
      int got;
      got = (k < grants.size()) ? grants[k] : -1;
      checkOne($sformatf("rr grant%0d", k), 128'(got), 128'(k % 2));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
